// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Decode-stage immediate generator. Each accepted instruction is decoded
//   combinationally into {imm, tag, fmt, err} and written into a 2-entry
//   FIFO skid buffer whose head drives the outputs from registers.
//
// Parameters
//   XLEN     : immediate width, 32 or 64
//   AUTO_FMT : 1 = format from opcode/funct3, 0 = format from i_imm_sel
//   TAG_W    : width of the sideband tag carried with each instruction
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_flush      : discard all buffered entries (and any same-cycle accept)
//   i_in_valid   : input instruction/tag/selector valid
//   o_in_ready   : buffer has room (registered count < 2)
//   i_in_instr   : 32-bit instruction word
//   i_in_tag     : sideband tag, passed through unchanged
//   i_imm_sel    : explicit format selector (only used when AUTO_FMT = 0)
//   o_out_valid  : head entry valid
//   i_out_ready  : consumer accepts the head entry
//   o_out_imm    : extended immediate of the head entry
//   o_out_tag    : tag of the head entry
//   o_out_fmt    : format code used for the head entry
//   o_out_err    : head entry had an illegal/unsupported format
module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit AUTO_FMT = 1'b1,
  parameter int TAG_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_instr,
  input  logic [TAG_W-1:0] i_in_tag,
  input  logic [2:0]       i_imm_sel,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_out_imm,
  output logic [TAG_W-1:0] o_out_tag,
  output logic [2:0]       o_out_fmt,
  output logic             o_out_err
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_Z     = 3'b101,
    FMT_SHAMT = 3'b110,
    FMT_INV   = 3'b111
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic [2:0]       fmt;
    logic             err;
  } entry_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  imm_fmt_e        w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_err;
  entry_t          w_new;
  logic            w_accept;
  logic            w_pop;
  logic            w_unused;

  logic [1:0]      r_count;
  entry_t          r_head;
  entry_t          r_tail;

  assign w_opcode = i_in_instr[6:0];
  assign w_funct3 = i_in_instr[14:12];

  // The selector only matters in explicit-format builds.
  assign w_unused = ^i_imm_sel;

  always_comb begin
    w_fmt = FMT_INV;
    if (AUTO_FMT) begin
      case (w_opcode)
        7'b0000011, 7'b1100111: w_fmt = FMT_I;
        7'b0010011: w_fmt = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
        7'b0100011: w_fmt = FMT_S;
        7'b1100011: w_fmt = FMT_B;
        7'b1101111: w_fmt = FMT_J;
        7'b0110111, 7'b0010111: w_fmt = FMT_U;
        7'b1110011: w_fmt = w_funct3[2] ? FMT_Z : FMT_I;
        default:    w_fmt = FMT_INV;
      endcase
    end else begin
      w_fmt = imm_fmt_e'(i_imm_sel);
    end
  end

  // Build a 32-bit immediate first; the zero-extended formats never set
  // bit 31, so a single sign extension to XLEN is correct for every format.
  always_comb begin
    w_imm32 = '0;
    w_err   = 1'b0;
    case (w_fmt)
      FMT_I:     w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
      FMT_S:     w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
      FMT_B:     w_imm32 = {{19{i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                            i_in_instr[30:25], i_in_instr[11:8], 1'b0};
      FMT_J:     w_imm32 = {{11{i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                            i_in_instr[20], i_in_instr[30:21], 1'b0};
      FMT_U:     w_imm32 = {i_in_instr[31:12], 12'b0};
      FMT_Z:     w_imm32 = {27'b0, i_in_instr[19:15]};
      FMT_SHAMT: w_imm32 = (XLEN == 64) ? {26'b0, i_in_instr[25:20]}
                                        : {27'b0, i_in_instr[24:20]};
      default: begin
        w_imm32 = '0;
        w_err   = 1'b1;
      end
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));
  assign w_new = {w_imm, i_in_tag, 3'(w_fmt), w_err};

  assign o_in_ready  = (r_count != 2'd2);
  assign o_out_valid = (r_count != 2'd0);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;

  // Head is only rewritten when it is being consumed or is empty, which
  // keeps the outputs stable under back-pressure. Flush only clears the
  // count; stale data behind out_valid=0 is never observed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop && r_count == 2'd2) begin
        r_head <= r_tail;
      end else if (w_accept && (r_count == 2'd0 || w_pop)) begin
        r_head <= w_new;
      end
      if (w_accept && r_count == 2'd1 && !w_pop) begin
        r_tail <= w_new;
      end
      r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
    end
  end

  assign o_out_imm = r_head.imm;
  assign o_out_tag = r_head.tag;
  assign o_out_fmt = r_head.fmt;
  assign o_out_err = r_head.err;

endmodule
